// File: rtl/tx_ffe_coef_responder.sv
// TX FFE coefficient responder: the TX end of the coefficient back-channel.
// It takes per-tap inc/dec/hold requests, applies them to the FFE tap weights
// within the per-tap and total-swing limits, and reports per-tap status over
// a level handshake.
// Optional build macro TX_FFE_PRESET_EN adds an i_preset input that reloads
// the initial coefficients from IDLE.
module tx_ffe_coef_responder #(
    parameter int Ntap     = 3,
    parameter int Mtap     = 1,
    parameter int Ncoef    = 7,
    parameter int STEP     = 1,
    parameter int CSUM_MAX = 31,
    parameter int MAIN_MIN = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef TX_FFE_PRESET_EN
    input  logic                   i_preset,
`endif
    input  logic                   i_req_valid,
    input  logic [2*Ntap-1:0]      i_req,
    output logic                   o_ack,
    output logic [2*Ntap-1:0]      o_stat,
    output logic [Ncoef*Ntap-1:0]  o_coef,
    output logic                   o_busy
);

    // One extra bit for candidates so that limit checks cannot wrap
    localparam int W       = Ncoef + 1;
    localparam int SW      = Ncoef + $clog2(Ntap);
    localparam int NEG_MAX = -CSUM_MAX;

    localparam logic signed [W-1:0]     MAIN_HI    = W'(CSUM_MAX);
    localparam logic signed [W-1:0]     MAIN_LO    = W'(MAIN_MIN);
    localparam logic signed [W-1:0]     SIDE_HI    = '0;
    localparam logic signed [W-1:0]     SIDE_LO    = W'(NEG_MAX);
    localparam logic signed [W-1:0]     STEP_W     = W'(STEP);
    localparam logic [SW-1:0]           CSUM_W     = SW'(CSUM_MAX);
    localparam logic signed [Ncoef-1:0] RESET_MAIN = Ncoef'(CSUM_MAX);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_ACK} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [Ncoef-1:0] r_coef     [Ntap];
    logic [1:0]              r_stat     [Ntap];
    logic [1:0]              r_req      [Ntap];
    logic signed [Ncoef-1:0] w_rstCoef  [Ntap];
    logic signed [W-1:0]     w_curExt   [Ntap];
    logic signed [W-1:0]     w_cand     [Ntap];
    logic [W-1:0]            w_mag      [Ntap];
    logic                    w_isInc    [Ntap];
    logic                    w_isDec    [Ntap];
    logic                    w_atLim    [Ntap];
    logic [1:0]              w_stat     [Ntap];
    logic [SW-1:0]           w_sum;
    logic                    w_reject;
    logic                    w_anyActive;

    // Initial coefficient set: full swing on the main tap, all others zero
    always_comb begin
        for (int k = 0; k < Ntap; k++) begin
            w_rstCoef[k] = (k == Mtap) ? RESET_MAIN : '0;
        end
    end

    // A live request needs at least one tap asking for inc or dec
    always_comb begin
        w_anyActive = 1'b0;
        for (int k = 0; k < Ntap; k++) begin
            if (i_req[2*k +: 2] == 2'b01 || i_req[2*k +: 2] == 2'b10) begin
                w_anyActive = 1'b1;
            end
        end
    end

    // Candidate tap set, total swing and per-tap status from the latched request
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Ntap; k++) begin
            w_isInc[k]  = (r_req[k] == 2'b01);
            w_isDec[k]  = (r_req[k] == 2'b10);
            w_curExt[k] = {r_coef[k][Ncoef-1], r_coef[k]};
            w_atLim[k]  = (w_isInc[k] && ((w_curExt[k] + STEP_W) >
                                          ((k == Mtap) ? MAIN_HI : SIDE_HI))) ||
                          (w_isDec[k] && ((w_curExt[k] - STEP_W) <
                                          ((k == Mtap) ? MAIN_LO : SIDE_LO)));
            w_cand[k] = w_curExt[k];
            if (w_isInc[k] && !w_atLim[k]) begin
                w_cand[k] = w_curExt[k] + STEP_W;
            end else if (w_isDec[k] && !w_atLim[k]) begin
                w_cand[k] = w_curExt[k] - STEP_W;
            end
            w_mag[k] = w_cand[k][W-1] ? W'(-w_cand[k]) : w_cand[k];
            w_sum    = w_sum + SW'(w_mag[k]);
        end
        w_reject = (w_sum > CSUM_W) || (w_cand[Mtap] < MAIN_LO);
        for (int k = 0; k < Ntap; k++) begin
            w_stat[k] = 2'b00;
            if (w_isInc[k] || w_isDec[k]) begin
                if (w_reject || w_atLim[k]) begin
                    w_stat[k] = w_isInc[k] ? 2'b11 : 2'b10;
                end else begin
                    w_stat[k] = 2'b01;
                end
            end
        end
    end

    // Handshake state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: request -> one update cycle -> hold ack until request released
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef TX_FFE_PRESET_EN
                if (i_preset) begin
                    w_next = S_ACK;
                end else
`endif
                if (i_req_valid && w_anyActive) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: w_next = S_ACK;
            S_ACK: begin
                if (!i_req_valid || !w_anyActive) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the request, commit all taps together, clear status on release
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < Ntap; k++) begin
                r_coef[k] <= w_rstCoef[k];
                r_stat[k] <= 2'b00;
                r_req[k]  <= 2'b00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef TX_FFE_PRESET_EN
                    if (i_preset) begin
                        for (int k = 0; k < Ntap; k++) begin
                            r_coef[k] <= w_rstCoef[k];
                            r_stat[k] <= (r_coef[k] != w_rstCoef[k]) ? 2'b01 : 2'b00;
                        end
                    end else
`endif
                    if (i_req_valid && w_anyActive) begin
                        for (int k = 0; k < Ntap; k++) begin
                            r_req[k] <= i_req[2*k +: 2];
                        end
                    end
                end
                S_UPDATE: begin
                    for (int k = 0; k < Ntap; k++) begin
                        r_stat[k] <= w_stat[k];
                        if (!w_reject) begin
                            r_coef[k] <= w_cand[k][Ncoef-1:0];
                        end
                    end
                end
                S_ACK: begin
                    if (w_next == S_IDLE) begin
                        for (int k = 0; k < Ntap; k++) begin
                            r_stat[k] <= 2'b00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack per-tap registers onto the output buses and derive handshake flags
    always_comb begin
        o_coef = '0;
        o_stat = '0;
        for (int k = 0; k < Ntap; k++) begin
            o_coef[k*Ncoef +: Ncoef] = r_coef[k];
            o_stat[2*k +: 2]         = r_stat[k];
        end
        o_ack  = (r_state == S_ACK);
        o_busy = (r_state == S_UPDATE) || (r_state == S_ACK);
    end

endmodule
